// File: rtl/spi_cfg_responder_if.sv
// Serial link between the SPI controller and the configuration responder.
// The controller owns frame enable, target select and data; the responder returns miso.
interface spi_cfg_responder_if;
    logic cs_b;
    logic spi_sel;
    logic mosi;
    logic miso;

    modport master (
        output cs_b,
        output spi_sel,
        output mosi,
        input  miso
    );

    modport slave (
        input  cs_b,
        input  spi_sel,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_cfg_responder.sv
// Chip-side responder for 40-bit controller frames: config register bank with
// read-back on miso, and DAC frame forwarding with a load strobe.
module spi_cfg_responder #(
    parameter int          NREG   = 8,
    parameter logic [31:0] DEV_ID = 32'h5745_4331
) (
    input  logic                     clk,
    input  logic                     rst_b,
    spi_cfg_responder_if.slave       spi,
    output logic [NREG*32-1:0]       cfg_flat,
    output logic                     cfg_wr,
    output logic [$clog2(NREG)-1:0]  cfg_wr_addr,
    output logic [39:0]              dac_word,
    output logic                     dac_load,
    output logic                     frame_err
);

    localparam int         AW      = $clog2(NREG);
    localparam logic [6:0] ID_ADDR = 7'h7F;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t        r_state;
    logic [5:0]    r_cnt;
    logic [38:0]   r_shift;
    logic          r_sel_q;
    logic [30:0]   r_rd;
    logic          r_miso;
    logic          r_committed;
    logic          r_ovf_seen;
    logic [31:0]   r_cfg [NREG];
    logic          r_cfg_wr;
    logic [AW-1:0] r_cfg_wr_addr;
    logic [39:0]   r_dac_word;
    logic          r_dac_load;
    logic          r_frame_err;

    logic [6:0]    w_hdr_addr;
    logic [31:0]   w_rdata;
    logic [39:0]   w_word;
    logic [6:0]    w_cmt_addr;
    logic          w_cmt_wr;

    // On edge 7 the address is the six stored header bits plus the live mosi bit.
    assign w_hdr_addr = {r_shift[5:0], spi.mosi};
    assign w_word     = {r_shift, spi.mosi};
    assign w_cmt_addr = w_word[38:32];
    assign w_cmt_wr   = !r_sel_q && !w_word[39] && (w_cmt_addr < 7'(NREG));

    // Read data is always the pre-frame contents, so write frames echo the old value too.
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is inferred.
        w_rdata = '0;
        if (!r_sel_q) begin
            if (w_hdr_addr == ID_ADDR) begin
                w_rdata = DEV_ID;
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    if (w_hdr_addr == 7'(i)) begin
                        w_rdata = r_cfg[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= ST_SYNC;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_sel_q       <= 1'b0;
            r_rd          <= '0;
            r_miso        <= 1'b0;
            r_committed   <= 1'b0;
            r_ovf_seen    <= 1'b0;
            // NOTE: the bank is a handful of flops, not a RAM, so resetting it is intended.
            for (int i = 0; i < NREG; i++) begin
                r_cfg[i] <= '0;
            end
            r_cfg_wr      <= 1'b0;
            r_cfg_wr_addr <= '0;
            r_dac_word    <= '0;
            r_dac_load    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            r_cfg_wr    <= 1'b0;
            r_dac_load  <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;

            case (r_state)
                ST_SYNC: begin
                    if (spi.cs_b) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (!spi.cs_b) begin
                        r_shift <= {r_shift[37:0], spi.mosi};
                        r_sel_q <= spi.spi_sel;
                        r_cnt   <= 6'd1;
                        r_state <= ST_HDR;
                    end
                end

                ST_HDR, ST_DATA: begin
                    // Truncation wins over a simultaneous sel mismatch: one pulse, back to IDLE.
                    if (spi.cs_b) begin
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                    end else if (spi.spi_sel != r_sel_q) begin
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_committed <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_shift <= {r_shift[37:0], spi.mosi};
                        r_cnt   <= r_cnt + 6'd1;
                        if (r_cnt == 6'd7) begin
                            r_miso  <= w_rdata[31];
                            r_rd    <= w_rdata[30:0];
                            r_state <= ST_DATA;
                        end else if (r_cnt == 6'd39) begin
                            if (r_sel_q) begin
                                r_dac_word <= w_word;
                                r_dac_load <= 1'b1;
                            end else if (w_cmt_wr) begin
                                for (int i = 0; i < NREG; i++) begin
                                    if (w_cmt_addr == 7'(i)) begin
                                        r_cfg[i] <= w_word[31:0];
                                    end
                                end
                                r_cfg_wr      <= 1'b1;
                                r_cfg_wr_addr <= w_cmt_addr[AW-1:0];
                            end
                            r_cnt       <= '0;
                            r_committed <= 1'b1;
                            r_ovf_seen  <= 1'b0;
                            r_state     <= ST_DONE;
                        end else if (r_state == ST_DATA) begin
                            r_miso <= r_rd[30];
                            r_rd   <= {r_rd[29:0], 1'b0};
                        end
                    end
                end

                ST_DONE: begin
                    // Over-length is only an error after a real commit, and only once per frame.
                    if (spi.cs_b) begin
                        r_state <= ST_IDLE;
                    end else if (r_committed && !r_ovf_seen) begin
                        r_frame_err <= 1'b1;
                        r_ovf_seen  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    always_comb begin
        cfg_flat = '0;
        for (int i = 0; i < NREG; i++) begin
            cfg_flat[32*i +: 32] = r_cfg[i];
        end
    end

    assign spi.miso    = r_miso;
    assign cfg_wr      = r_cfg_wr;
    assign cfg_wr_addr = r_cfg_wr_addr;
    assign dac_word    = r_dac_word;
    assign dac_load    = r_dac_load;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_cfg_responder.sv
// Scoreboarded bench for spi_cfg_responder: expected strobes are queued with the
// stimulus and matched as the responder emits them; miso and register state checked inline.
module tb_spi_cfg_responder;

    localparam int          NREG   = 8;
    localparam logic [31:0] DEV_ID = 32'h5745_4331;
    localparam logic [1:0]  K_WR   = 2'd0;
    localparam logic [1:0]  K_DAC  = 2'd1;
    localparam logic [1:0]  K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [6:0]  addr;
        logic [39:0] data;
    } ev_t;

    logic                clk;
    logic                rst_b;
    logic [NREG*32-1:0]  cfg_flat;
    logic                cfg_wr;
    logic [2:0]          cfg_wr_addr;
    logic [39:0]         dac_word;
    logic                dac_load;
    logic                frame_err;

    spi_cfg_responder_if sif ();

    spi_cfg_responder #(
        .NREG   (NREG),
        .DEV_ID (DEV_ID)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .spi         (sif),
        .cfg_flat    (cfg_flat),
        .cfg_wr      (cfg_wr),
        .cfg_wr_addr (cfg_wr_addr),
        .dac_word    (dac_word),
        .dac_load    (dac_load),
        .frame_err   (frame_err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    ev_t         exp_q [$];
    ev_t         mon_q [$];
    ev_t         exp_ev;
    logic [31:0] m_regs [NREG];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Strobe monitor: every emitted pulse must match the next queued expectation.
    always @(negedge clk) begin
        mon_q.delete();
        if (rst_b) begin
            if (cfg_wr)
                mon_q.push_back('{kind: K_WR, addr: 7'(cfg_wr_addr),
                                  data: {8'h00, cfg_flat[32*int'(cfg_wr_addr) +: 32]}});
            if (dac_load)
                mon_q.push_back('{kind: K_DAC, addr: 7'd0, data: dac_word});
            if (frame_err)
                mon_q.push_back('{kind: K_ERR, addr: 7'd0, data: 40'd0});
            foreach (mon_q[i]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%h, required none",
                             mon_q[i].kind, mon_q[i].addr, mon_q[i].data);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (mon_q[i] !== exp_ev)
                        $display("FAIL event_match: got kind=%0d addr=%0h data=%h, required kind=%0d addr=%0h data=%h",
                                 mon_q[i].kind, mon_q[i].addr, mon_q[i].data,
                                 exp_ev.kind, exp_ev.addr, exp_ev.data);
                    else
                        n_pass++;
                end
            end
        end
    end

    function automatic logic [NREG*32-1:0] model_flat();
        logic [NREG*32-1:0] f;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    // Drives nbits low edges; glitch_bit toggles spi_sel on that bit (nbits = on the release edge).
    task automatic send_frame(input logic sel, input logic [39:0] word, input int nbits,
                              input int glitch_bit, output logic [39:0] rx);
        rx = '0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            rx          = {rx[38:0], sif.miso};
            sif.cs_b    = 1'b0;
            sif.mosi    = (k < 40) ? word[39-k] : 1'b1;
            sif.spi_sel = (k == glitch_bit) ? ~sel : sel;
        end
        @(negedge clk);
        sif.cs_b    = 1'b1;
        sif.mosi    = 1'b0;
        sif.spi_sel = (nbits == glitch_bit) ? ~sel : sel;
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_pending: got %0d outstanding events, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        sif.cs_b = 1'b1; sif.spi_sel = 1'b0; sif.mosi = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cfg_flat !== '0) $display("FAIL reset_cfg_flat: got %h, required 0", cfg_flat);
        else n_pass++;
        n_checks++;
        if ({cfg_wr, dac_load, frame_err, sif.miso} !== 4'b0)
            $display("FAIL reset_strobes: got %b, required 0000", {cfg_wr, dac_load, frame_err, sif.miso});
        else n_pass++;
        n_checks++;
        if (dac_word !== 40'd0 || cfg_wr_addr !== 3'd0)
            $display("FAIL reset_words: got dac=%h addr=%0d, required 0/0", dac_word, cfg_wr_addr);
        else n_pass++;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [39:0] rx;
        logic [31:0] old;
        exp_q.push_back('{kind: K_WR, addr: 7'd3, data: {8'h00, 32'hDEAD_BEEF}});
        m_regs[3] = 32'hDEAD_BEEF;
        send_frame(1'b0, {1'b0, 7'd3, 32'hDEAD_BEEF}, 40, -1, rx);
        drain_check("write3");
        n_checks++;
        if (cfg_flat[127:96] !== m_regs[3]) $display("FAIL write3_reg: got %h, required %h", cfg_flat[127:96], m_regs[3]);
        else n_pass++;
        send_frame(1'b0, {1'b1, 7'd3, 32'h0}, 40, -1, rx);
        n_checks++;
        if (rx !== {8'h00, m_regs[3]}) $display("FAIL read3_miso: got %h, required %h", rx, {8'h00, m_regs[3]});
        else n_pass++;
        old = m_regs[3];
        exp_q.push_back('{kind: K_WR, addr: 7'd3, data: {8'h00, 32'hCAFE_F00D}});
        m_regs[3] = 32'hCAFE_F00D;
        send_frame(1'b0, {1'b0, 7'd3, 32'hCAFE_F00D}, 40, -1, rx);
        n_checks++;
        if (rx !== {8'h00, old}) $display("FAIL rbw_miso: got %h, required %h", rx, {8'h00, old});
        else n_pass++;
        drain_check("rbw");
    endtask

    task automatic test_id_unmapped();
        logic [39:0] rx;
        send_frame(1'b0, {1'b1, 7'h7F, 32'h0}, 40, -1, rx);
        n_checks++;
        if (rx !== {8'h00, DEV_ID}) $display("FAIL id_miso: got %h, required %h", rx, {8'h00, DEV_ID});
        else n_pass++;
        send_frame(1'b0, {1'b0, 7'h40, 32'h0000_1234}, 40, -1, rx);
        send_frame(1'b0, {1'b0, 7'h7F, 32'hFFFF_FFFF}, 40, -1, rx);
        send_frame(1'b0, {1'b1, 7'h40, 32'h0}, 40, -1, rx);
        n_checks++;
        if (rx !== 40'd0) $display("FAIL unmapped_miso: got %h, required 0", rx);
        else n_pass++;
        send_frame(1'b0, {1'b1, 7'h7F, 32'h0}, 40, -1, rx);
        n_checks++;
        if (rx !== {8'h00, DEV_ID}) $display("FAIL id_after_write: got %h, required %h", rx, {8'h00, DEV_ID});
        else n_pass++;
        drain_check("unmapped");
        n_checks++;
        if (cfg_flat !== model_flat()) $display("FAIL unmapped_flat: got %h, required %h", cfg_flat, model_flat());
        else n_pass++;
    endtask

    task automatic test_dac();
        logic [39:0] rx;
        exp_q.push_back('{kind: K_DAC, addr: 7'd0, data: 40'hA5_1234_5678});
        send_frame(1'b1, 40'hA5_1234_5678, 40, -1, rx);
        drain_check("dac");
        n_checks++;
        if (rx !== 40'd0) $display("FAIL dac_miso: got %h, required 0", rx);
        else n_pass++;
        n_checks++;
        if (dac_word !== 40'hA5_1234_5678) $display("FAIL dac_word: got %h, required %h", dac_word, 40'hA5_1234_5678);
        else n_pass++;
        n_checks++;
        if (cfg_flat !== model_flat()) $display("FAIL dac_flat: got %h, required %h", cfg_flat, model_flat());
        else n_pass++;
    endtask

    task automatic test_truncation();
        logic [39:0] rx;
        exp_q.push_back('{kind: K_ERR, addr: 7'd0, data: 40'd0});
        send_frame(1'b0, {1'b0, 7'd1, 32'h1111_2222}, 20, -1, rx);
        drain_check("trunc");
        n_checks++;
        if (cfg_flat[63:32] !== m_regs[1]) $display("FAIL trunc_reg1: got %h, required %h", cfg_flat[63:32], m_regs[1]);
        else n_pass++;
        exp_q.push_back('{kind: K_WR, addr: 7'd1, data: {8'h00, 32'h3333_4444}});
        m_regs[1] = 32'h3333_4444;
        send_frame(1'b0, {1'b0, 7'd1, 32'h3333_4444}, 40, -1, rx);
        drain_check("after_trunc");
        n_checks++;
        if (cfg_flat !== model_flat()) $display("FAIL after_trunc_flat: got %h, required %h", cfg_flat, model_flat());
        else n_pass++;
    endtask

    task automatic test_overlength_glitch();
        logic [39:0] rx;
        exp_q.push_back('{kind: K_WR, addr: 7'd2, data: {8'h00, 32'h2222_3333}});
        exp_q.push_back('{kind: K_ERR, addr: 7'd0, data: 40'd0});
        m_regs[2] = 32'h2222_3333;
        send_frame(1'b0, {1'b0, 7'd2, 32'h2222_3333}, 43, -1, rx);
        drain_check("overlength");
        exp_q.push_back('{kind: K_ERR, addr: 7'd0, data: 40'd0});
        send_frame(1'b0, {1'b0, 7'd2, 32'h4444_5555}, 40, 10, rx);
        drain_check("sel_glitch");
        exp_q.push_back('{kind: K_ERR, addr: 7'd0, data: 40'd0});
        send_frame(1'b0, {1'b0, 7'd5, 32'h5555_6666}, 12, 12, rx);
        drain_check("trunc_and_glitch");
        n_checks++;
        if (cfg_flat !== model_flat()) $display("FAIL glitch_flat: got %h, required %h", cfg_flat, model_flat());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [39:0] rx;
        exp_q.push_back('{kind: K_WR, addr: 7'd6, data: {8'h00, 32'h6666_0001}});
        exp_q.push_back('{kind: K_WR, addr: 7'd7, data: {8'h00, 32'h7777_0002}});
        m_regs[6] = 32'h6666_0001;
        m_regs[7] = 32'h7777_0002;
        send_frame(1'b0, {1'b0, 7'd6, 32'h6666_0001}, 40, -1, rx);
        send_frame(1'b0, {1'b0, 7'd7, 32'h7777_0002}, 40, -1, rx);
        send_frame(1'b0, {1'b1, 7'd6, 32'h0}, 40, -1, rx);
        n_checks++;
        if (rx !== {8'h00, m_regs[6]}) $display("FAIL b2b_read6: got %h, required %h", rx, {8'h00, m_regs[6]});
        else n_pass++;
        drain_check("b2b");
    endtask

    task automatic test_reset_midframe();
        logic [39:0] word;
        logic [39:0] rx;
        word = {1'b0, 7'd4, 32'h0BAD_F00D};
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            sif.cs_b = 1'b0; sif.spi_sel = 1'b0; sif.mosi = word[39-k];
        end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (cfg_flat !== '0 || dac_word !== 40'd0 || cfg_wr_addr !== 3'd0)
            $display("FAIL midreset_state: got flat=%h dac=%h addr=%0d, required all 0", cfg_flat, dac_word, cfg_wr_addr);
        else n_pass++;
        n_checks++;
        if ({cfg_wr, dac_load, frame_err, sif.miso} !== 4'b0)
            $display("FAIL midreset_strobes: got %b, required 0000", {cfg_wr, dac_load, frame_err, sif.miso});
        else n_pass++;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        rx = '0;
        for (int k = 15; k < 40; k++) begin
            if (k > 15) @(negedge clk);
            if (k == 16) rst_b = 1'b1;
            rx = {rx[38:0], sif.miso};
            sif.mosi = word[39-k];
        end
        @(negedge clk);
        sif.cs_b = 1'b1;
        drain_check("midreset_ignored");
        n_checks++;
        if (rx !== 40'd0 || cfg_flat !== model_flat())
            $display("FAIL midreset_residue: got miso=%h flat=%h, required 0/%h", rx, cfg_flat, model_flat());
        else n_pass++;
        exp_q.push_back('{kind: K_WR, addr: 7'd4, data: {8'h00, 32'h0BAD_F00D}});
        m_regs[4] = 32'h0BAD_F00D;
        send_frame(1'b0, word, 40, -1, rx);
        drain_check("post_reset_write");
        n_checks++;
        if (cfg_flat !== model_flat()) $display("FAIL post_reset_flat: got %h, required %h", cfg_flat, model_flat());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_id_unmapped();
        test_dac();
        test_truncation();
        test_overlength_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
